// File: rtl/sprite_motion_ctrl.sv
// ============================================================================
// sprite_motion_ctrl
// ----------------------------------------------------------------------------
// Player-sprite controller for the VGA game path. On each per-frame move tick
// it turns held-key levels into a clamped sprite position, a 4-way facing
// direction and a walk-animation frame index. Every clock it also maps the
// current scan pixel to a registered sprite-ROM address plus an in-sprite
// flag. Left-facing pixels are mirrored from the right-facing art, so a
// single ROM holds every frame.
//
// Optional build macro:
//   SPRITE_WRAP_EN - horizontal motion wraps around the screen instead of
//                    clamping at the walls. Vertical motion always clamps.
//
// Ports:
//   i_clk            system clock
//   i_rst_n          asynchronous, active-low reset
//   i_move_tick      one-cycle pulse per video frame; motion and animation
//                    update only on this pulse
//   i_key_up/down/left/right  held-key levels (already debounced)
//   i_x, i_y         current scan column / row
//   o_left_border    sprite left edge (registered)
//   o_up_border      sprite top edge (registered)
//   o_right_border   left + SPR_W - 1 (combinational)
//   o_down_border    up + SPR_H - 1 (combinational)
//   o_dir            facing: 0 up, 1 down, 2 left, 3 right
//   o_walking        high while in the WALK state
//   o_anim_frame     current walk-animation frame
//   o_rom_addr       sprite-ROM address for the previous cycle's (x,y)
//   o_in_sprite      previous cycle's (x,y) lay inside the sprite box
// ============================================================================
module sprite_motion_ctrl #(
    parameter int SPR_W    = 40,
    parameter int SPR_H    = 40,
    parameter int SCR_W    = 640,
    parameter int SCR_H    = 480,
    parameter int STEP     = 2,
    parameter int START_X  = 320,
    parameter int START_Y  = 240,
    parameter int FRAMES   = 4,
    parameter int ANIM_DIV = 8,
    parameter int ADDR_W   = 13
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_n,
    input  logic                                         i_move_tick,
    input  logic                                         i_key_up,
    input  logic                                         i_key_down,
    input  logic                                         i_key_left,
    input  logic                                         i_key_right,
    input  logic [9:0]                                   i_x,
    input  logic [9:0]                                   i_y,
    output logic [9:0]                                   o_left_border,
    output logic [9:0]                                   o_up_border,
    output logic [9:0]                                   o_right_border,
    output logic [9:0]                                   o_down_border,
    output logic [1:0]                                   o_dir,
    output logic                                         o_walking,
    output logic [((FRAMES > 1) ? $clog2(FRAMES) : 1)-1:0] o_anim_frame,
    output logic [ADDR_W-1:0]                            o_rom_addr,
    output logic                                         o_in_sprite
);

    localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int CNT_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [CNT_W-1:0]   ANIM_LAST = CNT_W'(ANIM_DIV - 1);
    localparam logic signed [11:0] STEP_S    = 12'(STEP);
    localparam logic signed [11:0] MAX_X_S   = 12'(SCR_W - SPR_W);
    localparam logic signed [11:0] MAX_Y_S   = 12'(SCR_H - SPR_H);
    localparam logic [9:0]         MAX_X     = 10'(SCR_W - SPR_W);
    localparam logic [9:0]         MAX_Y     = 10'(SCR_H - SPR_H);
    localparam logic [9:0]         COL_LAST  = 10'(SPR_W - 1);
    localparam logic [9:0]         ROW_LAST  = 10'(SPR_H - 1);
    localparam logic [ADDR_W-1:0]  FRAME_SZ  = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0]  ROW_SZ    = ADDR_W'(SPR_W);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    state_t               r_state;
    logic [9:0]           r_left;
    logic [9:0]           r_up;
    logic [1:0]           r_dir;
    logic [FRAME_W-1:0]   r_frame;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_in;

    logic                 w_goLeft, w_goRight, w_goUp, w_goDown;
    logic                 w_anyMove;
    logic signed [11:0]   w_dx, w_dy;
    logic signed [11:0]   w_sumX, w_sumY;
    logic [9:0]           w_nextLeft, w_nextUp;
    logic [1:0]           w_nextDir;
    logic [9:0]           w_right, w_down;
    logic                 w_inBox;
    logic [9:0]           w_colRaw, w_col, w_row;
    logic [ADDR_W-1:0]    w_addr;

    // Opposing keys cancel, so each direction flag is "this key and not its opposite".
    assign w_goLeft  = i_key_left  & ~i_key_right;
    assign w_goRight = i_key_right & ~i_key_left;
    assign w_goUp    = i_key_up    & ~i_key_down;
    assign w_goDown  = i_key_down  & ~i_key_up;
    assign w_anyMove = w_goLeft | w_goRight | w_goUp | w_goDown;

    assign w_dx = w_goLeft ? -STEP_S : (w_goRight ? STEP_S : 12'sd0);
    assign w_dy = w_goUp   ? -STEP_S : (w_goDown  ? STEP_S : 12'sd0);

    // Signed 12-bit sums so a step past 0 goes negative instead of wrapping at 10 bits.
    assign w_sumX = $signed({2'b00, r_left}) + w_dx;
    assign w_sumY = $signed({2'b00, r_up})   + w_dy;

    // Horizontal next position. A step that overshoots a wall lands exactly on
    // the wall; in wrap builds only a step taken from the wall itself wraps.
    always_comb begin
        w_nextLeft = w_sumX[9:0];
        if (w_sumX < 12'sd0) begin
`ifdef SPRITE_WRAP_EN
            w_nextLeft = (r_left == 10'd0) ? MAX_X : 10'd0;
`else
            w_nextLeft = 10'd0;
`endif
        end else if (w_sumX > MAX_X_S) begin
`ifdef SPRITE_WRAP_EN
            w_nextLeft = (r_left == MAX_X) ? 10'd0 : MAX_X;
`else
            w_nextLeft = MAX_X;
`endif
        end
    end

    // Vertical motion always clamps.
    always_comb begin
        w_nextUp = w_sumY[9:0];
        if (w_sumY < 12'sd0) begin
            w_nextUp = 10'd0;
        end else if (w_sumY > MAX_Y_S) begin
            w_nextUp = MAX_Y;
        end
    end

    // Horizontal intent wins over vertical; no intent keeps the old facing.
    always_comb begin
        w_nextDir = r_dir;
        if (w_goLeft) begin
            w_nextDir = DIR_LEFT;
        end else if (w_goRight) begin
            w_nextDir = DIR_RIGHT;
        end else if (w_goUp) begin
            w_nextDir = DIR_UP;
        end else if (w_goDown) begin
            w_nextDir = DIR_DOWN;
        end
    end

    // Motion/animation state: everything here only moves on the frame tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_left  <= 10'(START_X);
            r_up    <= 10'(START_Y);
            r_dir   <= DIR_RIGHT;
            r_frame <= '0;
            r_cnt   <= '0;
        end else if (i_move_tick) begin
            r_left <= w_nextLeft;
            r_up   <= w_nextUp;
            r_dir  <= w_nextDir;
            case (r_state)
                IDLE: begin
                    if (w_anyMove) begin
                        r_state <= WALK;
                        r_cnt   <= '0;
                        r_frame <= FRAME_W'(1);
                    end
                end
                WALK: begin
                    if (w_anyMove) begin
                        if (r_cnt == ANIM_LAST) begin
                            r_cnt   <= '0;
                            r_frame <= r_frame + FRAME_W'(1);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_frame <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_right = r_left + COL_LAST;
    assign w_down  = r_up + ROW_LAST;

    assign w_inBox = (i_x >= r_left) && (i_x <= w_right) &&
                     (i_y >= r_up)   && (i_y <= w_down);

    // Left-facing art is the right-facing art read back to front.
    assign w_colRaw = i_x - r_left;
    assign w_row    = i_y - r_up;
    assign w_col    = (r_dir == DIR_LEFT) ? (COL_LAST - w_colRaw) : w_colRaw;

    assign w_addr = ADDR_W'(r_frame) * FRAME_SZ + ADDR_W'(w_row) * ROW_SZ + ADDR_W'(w_col);

    // One-cycle pixel pipeline; address is forced to 0 outside the box.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
            r_in   <= 1'b0;
        end else begin
            r_in   <= w_inBox;
            r_addr <= w_inBox ? w_addr : '0;
        end
    end

    assign o_left_border  = r_left;
    assign o_up_border    = r_up;
    assign o_right_border = w_right;
    assign o_down_border  = w_down;
    assign o_dir          = r_dir;
    assign o_walking      = (r_state == WALK);
    assign o_anim_frame   = r_frame;
    assign o_rom_addr     = r_addr;
    assign o_in_sprite    = r_in;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// ============================================================================
// tb_sprite_motion_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for sprite_motion_ctrl. A main instance uses the default
// parameters; a second instance starts at (1,1) to reach the walls with a
// partial step. Pixel lookups go through a scoreboard queue: the expected
// result is pushed when (x,y) is driven and popped when the registered output
// appears one cycle later. Wrap expectations follow SPRITE_WRAP_EN.
// ============================================================================
module tb_sprite_motion_ctrl;

    localparam int ADDR_W = 13;

    logic        clk = 1'b0;
    logic        rstN;
    logic        tick, keyUp, keyDown, keyLeft, keyRight;
    logic        eTick, eKeyUp, eKeyDown, eKeyLeft, eKeyRight;
    logic [9:0]  x, y;

    logic [9:0]        leftB, upB, rightB, downB;
    logic [1:0]        dir;
    logic              walking;
    logic [1:0]        animFrame;
    logic [ADDR_W-1:0] romAddr;
    logic              inSprite;

    logic [9:0]        eLeftB, eUpB, eRightB, eDownB;
    logic [1:0]        eDir;
    logic              eWalking;
    logic [1:0]        eAnimFrame;
    logic [ADDR_W-1:0] eRomAddr;
    logic              eInSprite;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [9:0]        x;
        logic [9:0]        y;
        logic              expIn;
        logic [ADDR_W-1:0] expAddr;
    } pixVec_t;

    typedef struct {
        string             name;
        logic              expIn;
        logic [ADDR_W-1:0] expAddr;
    } sbEntry_t;

    sbEntry_t sbQueue[$];
    pixVec_t  pixTab[8];

    always #5 clk = ~clk;

    sprite_motion_ctrl u_dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_move_tick    (tick),
        .i_key_up       (keyUp),
        .i_key_down     (keyDown),
        .i_key_left     (keyLeft),
        .i_key_right    (keyRight),
        .i_x            (x),
        .i_y            (y),
        .o_left_border  (leftB),
        .o_up_border    (upB),
        .o_right_border (rightB),
        .o_down_border  (downB),
        .o_dir          (dir),
        .o_walking      (walking),
        .o_anim_frame   (animFrame),
        .o_rom_addr     (romAddr),
        .o_in_sprite    (inSprite)
    );

    sprite_motion_ctrl #(
        .START_X (1),
        .START_Y (1)
    ) u_edge (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_move_tick    (eTick),
        .i_key_up       (eKeyUp),
        .i_key_down     (eKeyDown),
        .i_key_left     (eKeyLeft),
        .i_key_right    (eKeyRight),
        .i_x            (x),
        .i_y            (y),
        .o_left_border  (eLeftB),
        .o_up_border    (eUpB),
        .o_right_border (eRightB),
        .o_down_border  (eDownB),
        .o_dir          (eDir),
        .o_walking      (eWalking),
        .o_anim_frame   (eAnimFrame),
        .o_rom_addr     (eRomAddr),
        .o_in_sprite    (eInSprite)
    );

    // Single comparison point: every check counts here and reports on failure.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Hold the given keys and issue nTicks move_tick pulses on the chosen instance.
    task automatic applyStimulus(input bit useEdge, input logic up, input logic down,
                                 input logic left, input logic right, input int nTicks);
        for (int i = 0; i < nTicks; i++) begin
            @(negedge clk);
            if (useEdge) begin
                eKeyUp = up; eKeyDown = down; eKeyLeft = left; eKeyRight = right;
                eTick  = 1'b1;
            end else begin
                keyUp = up; keyDown = down; keyLeft = left; keyRight = right;
                tick  = 1'b1;
            end
            @(negedge clk);
            tick  = 1'b0;
            eTick = 1'b0;
        end
    endtask

    // Drive one scan pixel, push its expectation, then pop and compare once the
    // registered result is out.
    task automatic probePixel(input string name, input logic [9:0] px, input logic [9:0] py,
                              input logic expIn, input logic [ADDR_W-1:0] expAddr);
        sbEntry_t e;
        @(negedge clk);
        x = px;
        y = py;
        e.name = name; e.expIn = expIn; e.expAddr = expAddr;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        if (sbQueue.size() == 0) begin
            checkOutput({name, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = sbQueue.pop_front();
            checkOutput({e.name, "_in"},   32'(inSprite), 32'(e.expIn));
            checkOutput({e.name, "_addr"}, 32'(romAddr),  32'(e.expAddr));
        end
    endtask

    // Watchdog so the run cannot hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [9:0] expLeftAfter;

        // Pixel vectors for the idle sprite at (320,240), frame 0, facing right.
        pixTab[0] = '{x: 10'd320, y: 10'd240, expIn: 1'b1, expAddr: 13'd0};
        pixTab[1] = '{x: 10'd359, y: 10'd279, expIn: 1'b1, expAddr: 13'd1599};
        pixTab[2] = '{x: 10'd330, y: 10'd245, expIn: 1'b1, expAddr: 13'd210};
        pixTab[3] = '{x: 10'd319, y: 10'd240, expIn: 1'b0, expAddr: 13'd0};
        pixTab[4] = '{x: 10'd360, y: 10'd240, expIn: 1'b0, expAddr: 13'd0};
        pixTab[5] = '{x: 10'd320, y: 10'd239, expIn: 1'b0, expAddr: 13'd0};
        pixTab[6] = '{x: 10'd320, y: 10'd280, expIn: 1'b0, expAddr: 13'd0};
        pixTab[7] = '{x: 10'd0,   y: 10'd0,   expIn: 1'b0, expAddr: 13'd0};

        rstN = 1'b0;
        tick = 1'b0; keyUp = 1'b0; keyDown = 1'b0; keyLeft = 1'b0; keyRight = 1'b0;
        eTick = 1'b0; eKeyUp = 1'b0; eKeyDown = 1'b0; eKeyLeft = 1'b0; eKeyRight = 1'b0;
        x = 10'd0; y = 10'd0;

        // Reset values.
        #12;
        checkOutput("rst_left",    32'(leftB),     32'd320);
        checkOutput("rst_up",      32'(upB),       32'd240);
        checkOutput("rst_dir",     32'(dir),       32'd3);
        checkOutput("rst_walking", 32'(walking),   32'd0);
        checkOutput("rst_frame",   32'(animFrame), 32'd0);
        checkOutput("rst_addr",    32'(romAddr),   32'd0);
        checkOutput("rst_in",      32'(inSprite),  32'd0);
        checkOutput("edge_rst_left", 32'(eLeftB),  32'd1);
        @(negedge clk);
        rstN = 1'b1;

        // Idle ticks leave everything in place.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        checkOutput("idle_left",    32'(leftB),     32'd320);
        checkOutput("idle_up",      32'(upB),       32'd240);
        checkOutput("idle_right",   32'(rightB),    32'd359);
        checkOutput("idle_down",    32'(downB),     32'd279);
        checkOutput("idle_dir",     32'(dir),       32'd3);
        checkOutput("idle_walking", 32'(walking),   32'd0);
        checkOutput("idle_frame",   32'(animFrame), 32'd0);

        // Keys held without a tick must not move anything.
        @(negedge clk);
        keyLeft = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("notick_left",    32'(leftB),   32'd320);
        checkOutput("notick_walking", 32'(walking), 32'd0);
        checkOutput("notick_dir",     32'(dir),     32'd3);
        keyLeft = 1'b0;

        // Pixel table against the idle sprite.
        for (int i = 0; i < 8; i++) begin
            probePixel($sformatf("pix%0d", i), pixTab[i].x, pixTab[i].y,
                       pixTab[i].expIn, pixTab[i].expAddr);
        end

        // Walk left 5 ticks: mirrored columns, frame 1.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        checkOutput("wl_left",    32'(leftB),     32'd310);
        checkOutput("wl_dir",     32'(dir),       32'd2);
        checkOutput("wl_walking", 32'(walking),   32'd1);
        checkOutput("wl_frame",   32'(animFrame), 32'd1);
        probePixel("wl_mirror0",  10'd310, 10'd240, 1'b1, 13'd1639);
        probePixel("wl_mirror39", 10'd349, 10'd241, 1'b1, 13'd1640);

        // Opposing horizontal keys cancel; up still moves and sets dir.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        checkOutput("cancel_left",  32'(leftB),     32'd310);
        checkOutput("cancel_up",    32'(upB),       32'd234);
        checkOutput("cancel_dir",   32'(dir),       32'd0);
        checkOutput("cancel_frame", 32'(animFrame), 32'd1);
        probePixel("up_unmirrored", 10'd311, 10'd234, 1'b1, 13'd1601);

        // Release: back to IDLE, facing kept.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("rel_walking", 32'(walking),   32'd0);
        checkOutput("rel_frame",   32'(animFrame), 32'd0);
        checkOutput("rel_dir",     32'(dir),       32'd0);

        // Animation cadence while walking right for 17 ticks.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("anim_t1", 32'(animFrame), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7);
        checkOutput("anim_t8", 32'(animFrame), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("anim_t9", 32'(animFrame), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8);
        checkOutput("anim_t17",  32'(animFrame), 32'd3);
        checkOutput("anim_left", 32'(leftB),     32'd344);
        checkOutput("anim_dir",  32'(dir),       32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("anim_rel_walking", 32'(walking),   32'd0);
        checkOutput("anim_rel_frame",   32'(animFrame), 32'd0);

        // Wall behaviour on the instance starting at (1,1).
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        checkOutput("edge_partial_left", 32'(eLeftB),   32'd0);
        checkOutput("edge_partial_up",   32'(eUpB),     32'd0);
        checkOutput("edge_partial_dir",  32'(eDir),     32'd2);
        checkOutput("edge_walking1",     32'(eWalking), 32'd1);
`ifdef SPRITE_WRAP_EN
        expLeftAfter = 10'd600;
`else
        expLeftAfter = 10'd0;
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        checkOutput("edge_wall_left", 32'(eLeftB),   32'(expLeftAfter));
        checkOutput("edge_wall_up",   32'(eUpB),     32'd0);
        checkOutput("edge_walking2",  32'(eWalking), 32'd1);
        checkOutput("edge_frame2",    32'(eAnimFrame), 32'd1);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 225);
        checkOutput("edge_down_clamp", 32'(eUpB),   32'd440);
        checkOutput("edge_down_bot",   32'(eDownB), 32'd479);
        checkOutput("edge_down_dir",   32'(eDir),   32'd1);
        checkOutput("edge_down_left",  32'(eLeftB), 32'(expLeftAfter));

`ifdef SPRITE_WRAP_EN
        expLeftAfter = 10'd0;
`else
        expLeftAfter = 10'd2;
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("edge_right1", 32'(eLeftB), 32'(expLeftAfter));

`ifdef SPRITE_WRAP_EN
        expLeftAfter = 10'd8;
`else
        expLeftAfter = 10'd600;
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 305);
        checkOutput("edge_right_far", 32'(eLeftB),   32'(expLeftAfter));
        checkOutput("edge_right_walk", 32'(eWalking), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // Asynchronous reset in the middle of a walk.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        checkOutput("mid_left",    32'(leftB),   32'd350);
        checkOutput("mid_walking", 32'(walking), 32'd1);
        probePixel("mid_pix", 10'd350, 10'd234, 1'b1, 13'd1600);
        keyRight = 1'b0;
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("arst_left",    32'(leftB),     32'd320);
        checkOutput("arst_up",      32'(upB),       32'd240);
        checkOutput("arst_dir",     32'(dir),       32'd3);
        checkOutput("arst_walking", 32'(walking),   32'd0);
        checkOutput("arst_frame",   32'(animFrame), 32'd0);
        checkOutput("arst_in",      32'(inSprite),  32'd0);
        checkOutput("arst_addr",    32'(romAddr),   32'd0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Parametrised player-sprite controller for the VGA game path. It takes held-key levels and a per-frame move tick, and maintains a clamped sprite position, a 4-way facing direction and a walk-animation frame index. It also produces a registered sprite-ROM address and an in-sprite flag for the current scan pixel. Left-facing pixels are horizontally mirrored from the right-facing art, so one ROM holds all frames.

Parameters:
SPR_W, 40, sprite width in pixels
SPR_H, 40, sprite height in pixels
SCR_W, 640, visible screen width
SCR_H, 480, visible screen height
STEP, 2, pixels moved per move_tick per axis
START_X, 320, reset left border
START_Y, 240, reset up border
FRAMES, 4, walk-animation frames stored in ROM (power of 2)
ANIM_DIV, 8, move_ticks per animation frame advance
ADDR_W, 13, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H*FRAMES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
move_tick  in  1  one-cycle pulse per video frame; all motion and animation updates happen only on this pulse
key_up, key_down, key_left, key_right  in  1 each  held-key levels, already debounced
x  in  10  current scan column
y  in  10  current scan row
left_border, up_border  out  10  sprite top-left position (registered)
right_border, down_border  out  10  left+SPR_W-1 and up+SPR_H-1 (combinational from the registers)
dir  out  2  facing: 0 up, 1 down, 2 left, 3 right
walking  out  1  high while in the WALK state
anim_frame  out  log2(FRAMES)  current animation frame
rom_addr  out  ADDR_W  sprite ROM address for (x,y), registered
in_sprite  out  1  (x,y) lies inside the sprite box, registered and aligned with rom_addr

Behaviour:
- Reset (asynchronous assert, synchronous release on the next clk edge):
  - left=START_X, up=START_Y, dir=3, walking=0, anim_frame=0, anim count=0, rom_addr=0, in_sprite=0.
- Without move_tick, position, dir, state and animation hold. Key changes between ticks have no effect.
- Axis intent, evaluated on move_tick:
  - vx = right-left, vy = down-up. Opposing keys held together cancel to 0 on that axis.
- Position update on move_tick:
  - left += STEP*vx, clamped to [0, SCR_W-SPR_W].
  - up += STEP*vy, clamped to [0, SCR_H-SPR_H].
  - Compute with signed 12-bit intermediates so there is no 10-bit wrap at 0.
  - A partial step to the edge is allowed, e.g. left=1, STEP=2, moving left gives left=0.
- dir update on move_tick, only when the corresponding axis intent is nonzero:
  - Horizontal wins over vertical: vx<0 gives 2, vx>0 gives 3, else vy<0 gives 0, vy>0 gives 1.
  - No intent leaves dir unchanged.
  - Pushing into a wall still updates dir.
- State machine (IDLE, WALK), transitions only on move_tick:
  - IDLE goes to WALK when any axis intent is nonzero; anim count=0, anim_frame=1.
  - WALK stays in WALK while intent is nonzero. The count increments; on reaching ANIM_DIV-1 it resets to 0 and anim_frame advances, wrapping FRAMES-1 to 0.
  - WALK goes to IDLE when intent is zero; anim_frame=0, count=0.
  - Position clamped at a wall with intent still nonzero keeps the state in WALK and keeps animating.
- Pixel path (1-cycle latency: rom_addr and in_sprite at cycle N+1 correspond to x,y at cycle N):
  - in_sprite = (left<=x<=right) and (up<=y<=down).
  - col = x-left, row = y-up.
  - When dir==2, col is mirrored to SPR_W-1-col.
  - rom_addr = anim_frame*SPR_W*SPR_H + row*SPR_W + col.
  - When not in_sprite, rom_addr=0.
  - Up and down facing use the unmirrored right-facing frames.
- Position registers update only on move_tick, so borders are stable within a frame except for the tick cycle. Drive move_tick in vertical blank.

Optional Feature:
- Macro SPRITE_WRAP_EN.
- Defined: horizontal motion wraps instead of clamping.
  - A left step below 0 gives left = SCR_W-SPR_W.
  - A right step above SCR_W-SPR_W gives left = 0.
  - Vertical motion still clamps.
- Undefined: both axes clamp as described above.

Test Plan:
- Reset release, no keys, 10 move_ticks -> left=320, up=240, dir=3, walking=0, anim_frame=0, in_sprite=1 one cycle after x=320, y=240 with rom_addr=0.
- Hold key_left for 5 ticks -> left=310, dir=2, walking=1. At x=310, y=240 the next cycle gives rom_addr = anim_frame*1600+39.
- Hold key_left and key_right together plus key_up for 3 ticks -> left unchanged, up=234, dir=0.
- Start at left=1 and hold left for 1 tick -> left=0; further ticks keep left=0 and walking=1. With SPRITE_WRAP_EN, the second tick gives left=600.
- Hold right for 17 ticks from idle -> anim_frame sequence ends at 3 (1 at tick1, 2 at tick9, 3 at tick17). Release keys, 1 tick -> walking=0, anim_frame=0.
- Assert rst low mid-walk, off clock edge -> all outputs return to reset values immediately, without waiting for a clk edge.
